// File: rtl/temp_sampler.sv
// rtl/temp_sampler.sv - serial temperature sensor front-end with saturation, optional averaging and fault flag
// Optional 4-tap moving average enabled by defining TEMP_SAMPLER_AVG_EN.
module temp_sampler #(
    parameter int SAMPLE_PERIOD = 100,
    parameter int FAULT_LIMIT   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdi,
    output logic       cs_n,
    output logic [4:0] temp,
    output logic       temp_valid,
    output logic       sensor_fault
);

    localparam int CW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    FL       = 3'(FAULT_LIMIT);
    localparam logic [4:0]    RST_TEMP = 5'd20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_raw;
    logic [4:0]    r_temp;
    logic          r_temp_valid;
    logic [2:0]    r_fault_cnt;

    logic          w_invalid;
    logic [4:0]    w_sample;
    logic [4:0]    w_filtered;

    assign w_invalid = (r_raw == 8'hFF);
    assign w_sample  = (r_raw > 8'd31) ? 5'd31 : r_raw[4:0];

`ifdef TEMP_SAMPLER_AVG_EN
    // The incoming sample is the newest of the four taps; r_tap holds the three before it.
    logic [4:0] r_tap [3];
    logic [6:0] w_sum;
    logic [6:0] w_sum_rnd;

    assign w_sum      = {2'b00, w_sample} + {2'b00, r_tap[0]} + {2'b00, r_tap[1]} + {2'b00, r_tap[2]};
    assign w_sum_rnd  = w_sum + 7'd2;
    assign w_filtered = w_sum_rnd[6:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap[0] <= RST_TEMP;
            r_tap[1] <= RST_TEMP;
            r_tap[2] <= RST_TEMP;
        end else if (r_state == UPDATE && !w_invalid) begin
            r_tap[0] <= w_sample;
            r_tap[1] <= r_tap[0];
            r_tap[2] <= r_tap[1];
        end
    end
`else
    assign w_filtered = w_sample;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_cnt == CNT_LAST) w_next = SHIFT;
            SHIFT:   if (r_bit == 3'd7) w_next = UPDATE;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_raw        <= 8'd0;
            r_temp       <= RST_TEMP;
            r_temp_valid <= 1'b0;
            r_fault_cnt  <= 3'd0;
        end else begin
            r_state      <= w_next;
            r_temp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
                    r_bit <= 3'd0;
                end
                SHIFT: begin
                    r_raw <= {r_raw[6:0], sdi};
                    r_bit <= r_bit + 3'd1;
                end
                UPDATE: begin
                    // An all-ones frame means nothing drove the bus: hold temp, count the miss.
                    if (w_invalid) begin
                        if (r_fault_cnt != FL) r_fault_cnt <= r_fault_cnt + 3'd1;
                    end else begin
                        r_fault_cnt  <= 3'd0;
                        r_temp       <= w_filtered;
                        r_temp_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cs_n         = (r_state != SHIFT);
    assign temp         = r_temp;
    assign temp_valid   = r_temp_valid;
    assign sensor_fault = (r_fault_cnt == FL);

endmodule

// File: tb/tb_temp_sampler.sv
// tb/tb_temp_sampler.sv - randomized self-checking bench for temp_sampler against a frame-timeline model
module tb_temp_sampler;

    localparam int SP = 4;
    localparam int FL = 3;
    localparam int FP = SP + 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sdi = 1'b0;
    logic       cs_n;
    logic [4:0] temp;
    logic       temp_valid;
    logic       sensor_fault;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: cycle position since reset, and what the outputs must be after each edge.
    int         m_t     = 0;
    int         m_temp  = 20;
    int         m_tv    = 0;
    int         m_fc    = 0;
    int         m_tap [4] = '{20, 20, 20, 20};
    logic [7:0] m_raw   = 8'd0;

    logic [7:0] byte_q [$];
    logic [7:0] cur_byte = 8'd0;

    temp_sampler #(.SAMPLE_PERIOD(SP), .FAULT_LIMIT(FL)) dut (
        .clk          (clk),
        .rst          (rst),
        .sdi          (sdi),
        .cs_n         (cs_n),
        .temp         (temp),
        .temp_valid   (temp_valid),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sensor side: serve the scheduled byte MSB first while the model says SHIFT; noise otherwise.
    always @(negedge clk) begin
        int p;
        p = m_t % FP;
        if (p == SP) begin
            if (byte_q.size() > 0) cur_byte = byte_q.pop_front();
            else                   cur_byte = 8'($urandom);
        end
        if (p >= SP && p <= SP + 7) sdi = cur_byte[7 - (p - SP)];
        else                        sdi = 1'($urandom_range(0, 1));
    end

    always @(posedge clk) begin
        int p;
        int s;
        int sum;
        if (rst) begin
            m_t = 0; m_temp = 20; m_tv = 0; m_fc = 0;
            for (int i = 0; i < 4; i++) m_tap[i] = 20;
        end else begin
            p = m_t % FP;
            m_tv = 0;
            if (p >= SP && p <= SP + 7) begin
                m_raw[7 - (p - SP)] = sdi;
            end else if (p == SP + 8) begin
                if (m_raw == 8'hFF) begin
                    if (m_fc < FL) m_fc++;
                end else begin
                    m_fc = 0;
                    s = (int'(m_raw) > 31) ? 31 : int'(m_raw);
                    for (int i = 3; i > 0; i--) m_tap[i] = m_tap[i-1];
                    m_tap[0] = s;
                    sum = m_tap[0] + m_tap[1] + m_tap[2] + m_tap[3];
`ifdef TEMP_SAMPLER_AVG_EN
                    m_temp = (sum + 2) / 4;
`else
                    m_temp = s;
`endif
                    m_tv = 1;
                end
            end
            m_t++;
        end
        #1;
        if (chk_en) begin
            p = m_t % FP;
            check("cs_n",         32'(cs_n),         (p >= SP && p <= SP + 7) ? 0 : 1);
            check("temp",         32'(temp),         m_temp);
            check("temp_valid",   32'(temp_valid),   m_tv);
            check("sensor_fault", 32'(sensor_fault), (m_fc == FL) ? 1 : 0);
        end
    end

    task automatic do_reset();
        byte_q.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_temp",  32'(temp),         20);
        check("reset_cs_n",  32'(cs_n),         1);
        check("reset_valid", 32'(temp_valid),   0);
        check("reset_fault", 32'(sensor_fault), 0);
        chk_en = 1'b1;
        rst    = 1'b0;
    endtask

    task automatic run_frames(input int n);
        repeat (n * FP) @(negedge clk);
    endtask

    initial begin
        int exp_v;
        bit found;

        // Steady readings of 20.
        do_reset();
        repeat (3) byte_q.push_back(8'd20);
        run_frames(3);
        check("steady20_temp",  32'(temp),       20);
        check("steady20_valid", 32'(temp_valid), 1);

        // Step to 28 from the reset taps.
        do_reset();
        repeat (4) byte_q.push_back(8'd28);
        run_frames(1);
`ifdef TEMP_SAMPLER_AVG_EN
        exp_v = 22;
`else
        exp_v = 28;
`endif
        check("first28_temp", 32'(temp), exp_v);
        run_frames(3);
        check("four28_temp", 32'(temp), 28);

        // Saturation.
        repeat (4) byte_q.push_back(8'd200);
        run_frames(4);
        check("sat200_temp", 32'(temp), 31);

        // Three absent-sensor frames, then recovery.
        repeat (3) byte_q.push_back(8'hFF);
        run_frames(2);
        check("ff2_fault", 32'(sensor_fault), 0);
        run_frames(1);
        check("ff3_fault", 32'(sensor_fault), 1);
        check("ff3_valid", 32'(temp_valid),   0);
        check("ff3_temp",  32'(temp),         31);
        byte_q.push_back(8'd18);
        run_frames(1);
`ifdef TEMP_SAMPLER_AVG_EN
        exp_v = 28;
`else
        exp_v = 18;
`endif
        check("recover_fault", 32'(sensor_fault), 0);
        check("recover_valid", 32'(temp_valid),   1);
        check("recover_temp",  32'(temp),         exp_v);

        // Invalid, invalid, valid, invalid, invalid: never faults.
        byte_q.push_back(8'hFF); byte_q.push_back(8'hFF); byte_q.push_back(8'd5);
        byte_q.push_back(8'hFF); byte_q.push_back(8'hFF);
        run_frames(5);
        check("mixed_fault", 32'(sensor_fault), 0);

        // Reset during the 4th shift bit.
        do_reset();
        byte_q.push_back(8'd25);
        found = 1'b0;
        for (int i = 0; i < FP && !found; i++) begin
            @(negedge clk);
            if (m_t % FP == SP + 3) found = 1'b1;
        end
        check("midframe_reached", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_cs_n",  32'(cs_n),       1);
        check("midframe_temp",  32'(temp),       20);
        check("midframe_valid", 32'(temp_valid), 0);
        rst = 1'b0;
        byte_q.delete();
        byte_q.push_back(8'd9);
        run_frames(1);
`ifdef TEMP_SAMPLER_AVG_EN
        exp_v = 17;
`else
        exp_v = 9;
`endif
        check("after_abort_temp", 32'(temp), exp_v);

        // Randomized frames, about a quarter of them invalid.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       byte_q.push_back(8'hFF);
                1:       byte_q.push_back(8'($urandom_range(0, 40)));
                default: byte_q.push_back(8'($urandom));
            endcase
        end
        run_frames(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/temp_sampler.md
Name: temp_sampler

Overview:
- Upstream front-end for the air-conditioning controller.
- Periodically reads an 8-bit serial temperature sensor and saturates each reading to 0..31 °C.
- Optionally smooths readings with a 4-sample moving average, and drives the controller's 5-bit temperature input.
- Flags a sensor fault after repeated invalid reads.

Parameters:
- SAMPLE_PERIOD, 100: IDLE cycles between conversions (must be >= 2).
- FAULT_LIMIT, 3: consecutive invalid reads before sensor_fault asserts (range 1..7).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sdi  input  1  serial data from sensor, MSB first, valid while cs_n=0
- cs_n  output  1  sensor chip select, active low; low only in SHIFT
- temp  output  5  filtered temperature in whole °C, unsigned, to controller
- temp_valid  output  1  one-cycle pulse when temp has been updated
- sensor_fault  output  1  high while the consecutive invalid-read count equals FAULT_LIMIT

Behaviour:
- Reset values (rst high at a clock edge):
  - state=IDLE, period counter=0, cs_n=1.
  - temp=5'd20 (mid comfort band, so the controller idles).
  - temp_valid=0, sensor_fault=0, fault count=0.
  - All four average taps=5'd20.
- rst mid-frame: abort immediately, cs_n=1 on the next cycle, discard partial shift data.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - Counter counts 0..SAMPLE_PERIOD-1.
  - At count SAMPLE_PERIOD-1, go to SHIFT and drive cs_n=0; the counter clears.
- SHIFT:
  - Exactly 8 cycles with cs_n=0.
  - Bit index k=0..7 samples sdi on the k-th rising edge into raw[7-k].
  - After the 8th bit, go to UPDATE; cs_n=1 from UPDATE onward.
- UPDATE:
  - Single cycle; processes raw, then returns to IDLE.
  - Frame period = SAMPLE_PERIOD+9 cycles.
- Invalid read: raw==8'hFF (sensor absent, bus pulled high).
  - Sample is not used; temp is held and temp_valid is not pulsed.
  - Fault count increments, saturating at FAULT_LIMIT.
  - sensor_fault=1 when count==FAULT_LIMIT.
- Valid read: fault count clears to 0 and sensor_fault clears in the same update.
  - Saturation: s = (raw>31) ? 31 : raw[4:0].
  - s is pushed into the tap shift register (tap0=s, oldest tap dropped).
  - temp = new filtered value (see Optional Feature).
  - temp_valid=1 for exactly one cycle: the cycle after UPDATE, i.e. the first IDLE cycle.
- Registered-output latency: temp and temp_valid change one clock after the UPDATE cycle. sensor_fault updates on the same edge.
- Arithmetic:
  - The tap sum is 7 bits wide (max 124).
  - Average = (sum+2)>>2, round half up; the result is always <= 31, so no overflow.
- temp changes only with temp_valid high. Between pulses temp is stable.

Optional Feature:
- Macro: TEMP_SAMPLER_AVG_EN.
- Defined: temp = rounded mean of the 4 taps, including the new sample.
  - Taps start at 20 after reset, so the first valid read of s gives (60+s+2)>>2.
- Undefined:
  - Taps and adder are not built.
  - temp = s directly on each valid read.
- All other behaviour is identical in both builds (timing, fault handling, saturation, reset values).

Test Plan:
- Reset, then raw=8'd20 each frame with SAMPLE_PERIOD=4:
  - cs_n low for exactly 8 cycles, starting after 4 IDLE cycles.
  - temp_valid pulses every 13 cycles with temp=20.
- AVG_EN defined, reset, first valid raw=8'd28:
  - temp=(60+28+2)>>2=22.
  - After 4 consecutive reads of 28, temp=28.
- Saturation, raw=8'd200:
  - AVG_EN off: temp=31.
  - AVG_EN on, after 4 reads: temp=31, no wrap.
- FAULT_LIMIT=3, three frames of raw=8'hFF:
  - No temp_valid pulses and temp held.
  - sensor_fault rises after the 3rd UPDATE.
  - A following raw=8'd18 clears sensor_fault and pulses temp_valid.
- rst asserted during the 4th SHIFT bit:
  - cs_n=1 next cycle, temp=20, no temp_valid.
  - Next frame starts after a full SAMPLE_PERIOD.
- Two invalid reads, then one valid, then two invalid (FAULT_LIMIT=3):
  - sensor_fault never asserts (the count resets on the valid read).
